// File: rtl/dt_pkg.sv
// Shared constants, FSM encoding and address check for the digital-tube
// display write arbiter.
package dt_pkg;

    localparam logic [31:0] DT_SIGN_ADDR = 32'h0000_7f38;
    localparam logic [31:0] DT_DATA_ADDR = 32'h0000_7f3c;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } dt_state_e;

    function automatic logic dt_addr_ok(input logic [31:0] addr);
        return (addr == DT_SIGN_ADDR) || (addr == DT_DATA_ADDR);
    endfunction

endpackage

// File: rtl/dt_hold_timer.sv
// Monitor lockout timer: reloads on a CPU DATA write, then counts down to zero.
// A zero HOLD_CYCLES value means the lockout never becomes active.
module dt_hold_timer #(
    parameter logic [23:0] HOLD_CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_hold_active
);

    logic [23:0] r_count;

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= HOLD_CYCLES;
        end else if (r_count != '0) begin
            r_count <= r_count - 24'd1;
        end
    end

    assign o_hold_active = (r_count != '0);

endmodule

// File: rtl/dt_write_arbiter.sv
// Two-requester arbiter for the display driver's write port. The CPU has fixed
// priority; each granted request becomes one registered write cycle.
module dt_write_arbiter
    import dt_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    input  logic        mon_en,
    input  logic        mon_req,
    input  logic [31:0] mon_addr,
    input  logic [31:0] mon_wdata,
    output logic        mon_gnt,
    output logic        drv_we,
    output logic [31:0] drv_addr,
    output logic [31:0] drv_wdata,
    output logic        addr_err,
    output logic        hold_active
);

    dt_state_e   r_state;
    dt_state_e   w_next_state;

    logic        r_cpu_gnt;
    logic        r_mon_gnt;
    logic        r_drv_we;
    logic        r_addr_err;
    logic [31:0] r_drv_addr;
    logic [31:0] r_drv_wdata;

    logic        w_cpu_gnt;
    logic        w_mon_gnt;
    logic        w_drv_we;
    logic        w_addr_err;
    logic [31:0] w_drv_addr;
    logic [31:0] w_drv_wdata;

    logic        w_hold_active;
    logic        w_hold_load;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_cpu_gnt    = 1'b0;
        w_mon_gnt    = 1'b0;
        w_drv_we     = 1'b0;
        w_addr_err   = 1'b0;
        w_drv_addr   = r_drv_addr;
        w_drv_wdata  = r_drv_wdata;

        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    w_next_state = ST_ISSUE;
                    w_cpu_gnt    = 1'b1;
                    w_drv_addr   = cpu_addr;
                    w_drv_wdata  = cpu_wdata;
                    w_drv_we     = dt_addr_ok(cpu_addr);
                    w_addr_err   = !dt_addr_ok(cpu_addr);
                end else if (mon_req && mon_en && !w_hold_active) begin
                    w_next_state = ST_ISSUE;
                    w_mon_gnt    = 1'b1;
                    w_drv_addr   = mon_addr;
                    w_drv_wdata  = mon_wdata;
                    w_drv_we     = dt_addr_ok(mon_addr);
                    w_addr_err   = !dt_addr_ok(mon_addr);
                end
            end
            ST_ISSUE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Grant/enable registers are computed one state early so they are high
    // exactly during the ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cpu_gnt   <= 1'b0;
            r_mon_gnt   <= 1'b0;
            r_drv_we    <= 1'b0;
            r_addr_err  <= 1'b0;
            r_drv_addr  <= '0;
            r_drv_wdata <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cpu_gnt   <= w_cpu_gnt;
            r_mon_gnt   <= w_mon_gnt;
            r_drv_we    <= w_drv_we;
            r_addr_err  <= w_addr_err;
            r_drv_addr  <= w_drv_addr;
            r_drv_wdata <= w_drv_wdata;
        end
    end

    // Only a successful CPU write to DATA restarts the monitor lockout.
    assign w_hold_load = r_cpu_gnt && r_drv_we && (r_drv_addr == DT_DATA_ADDR);

    dt_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_load        (w_hold_load),
        .o_hold_active (w_hold_active)
    );

    assign cpu_gnt     = r_cpu_gnt;
    assign mon_gnt     = r_mon_gnt;
    assign drv_we      = r_drv_we;
    assign addr_err    = r_addr_err;
    assign drv_addr    = r_drv_addr;
    assign drv_wdata   = r_drv_wdata;
    assign hold_active = w_hold_active;

endmodule
